// File: rtl/icb_arb2.sv
// Two-master ICB arbiter (round-robin, one outstanding txn, response timeout); cmd passes through combinationally in IDLE.
// Backpressure: slave cmd_ready locks the grant until handshake; owner rsp_ready drives slave rsp_ready while BUSY.
module icb_arb2 #(
    parameter int unsigned TOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_icb_cmd_valid,
    output logic        m0_icb_cmd_ready,
    input  logic        m0_icb_cmd_read,
    input  logic [31:0] m0_icb_cmd_addr,
    input  logic [31:0] m0_icb_cmd_wdata,
    input  logic [3:0]  m0_icb_cmd_wmask,
    output logic        m0_icb_rsp_valid,
    input  logic        m0_icb_rsp_ready,
    output logic        m0_icb_rsp_err,
    output logic [31:0] m0_icb_rsp_rdata,

    input  logic        m1_icb_cmd_valid,
    output logic        m1_icb_cmd_ready,
    input  logic        m1_icb_cmd_read,
    input  logic [31:0] m1_icb_cmd_addr,
    input  logic [31:0] m1_icb_cmd_wdata,
    input  logic [3:0]  m1_icb_cmd_wmask,
    output logic        m1_icb_rsp_valid,
    input  logic        m1_icb_rsp_ready,
    output logic        m1_icb_rsp_err,
    output logic [31:0] m1_icb_rsp_rdata,

    output logic        s_icb_cmd_valid,
    input  logic        s_icb_cmd_ready,
    output logic        s_icb_cmd_read,
    output logic [31:0] s_icb_cmd_addr,
    output logic [31:0] s_icb_cmd_wdata,
    output logic [3:0]  s_icb_cmd_wmask,
    input  logic        s_icb_rsp_valid,
    output logic        s_icb_rsp_ready,
    input  logic        s_icb_rsp_err,
    input  logic [31:0] s_icb_rsp_rdata,

    output logic        owner_o,
    output logic        tout_o
);

    typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

    localparam logic [15:0] TOUT_LIM = 16'(TOUT_CYC);

    state_t      state, state_nxt;
    logic        last_gnt, lock, lock_gnt, owner, tout_q;
    logic [15:0] cnt, cnt_inc;
    logic        gnt, in_idle, in_busy, in_tout;
    logic        cmd_hs, rsp_hs, own_rdy, fwd_vld;

    assign in_idle = (state == IDLE);
    assign in_busy = (state == BUSY);
    assign in_tout = (state == TOUT);

    always_comb begin
        gnt = 1'b0;
        if (lock)
            gnt = lock_gnt;
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
            gnt = ~last_gnt;
        else if (m1_icb_cmd_valid)
            gnt = 1'b1;
    end

    // rst_n gating keeps the combinational cmd path quiet while reset is held
    assign s_icb_cmd_valid  = rst_n && in_idle && (gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid);
    assign s_icb_cmd_read   = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_addr   = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_wdata  = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign m0_icb_cmd_ready = rst_n && in_idle && !gnt && s_icb_cmd_ready;
    assign m1_icb_cmd_ready = rst_n && in_idle &&  gnt && s_icb_cmd_ready;
    assign cmd_hs           = s_icb_cmd_valid && s_icb_cmd_ready;

    assign own_rdy          = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
    assign s_icb_rsp_ready  = in_busy ? own_rdy : 1'b1;
    assign rsp_hs           = s_icb_rsp_valid && s_icb_rsp_ready;
    assign fwd_vld          = (in_busy && s_icb_rsp_valid) || in_tout;

    assign m0_icb_rsp_valid = fwd_vld && !owner;
    assign m1_icb_rsp_valid = fwd_vld &&  owner;
    assign m0_icb_rsp_err   = !owner && ((in_busy && s_icb_rsp_err) || in_tout);
    assign m1_icb_rsp_err   =  owner && ((in_busy && s_icb_rsp_err) || in_tout);
    assign m0_icb_rsp_rdata = (in_busy && !owner) ? s_icb_rsp_rdata : 32'h0;
    assign m1_icb_rsp_rdata = (in_busy &&  owner) ? s_icb_rsp_rdata : 32'h0;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign owner_o = owner;
    assign tout_o  = tout_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_hs) state_nxt = BUSY;
            // a response arriving on the deadline cycle beats the timeout
            BUSY: begin
                if (rsp_hs)
                    state_nxt = IDLE;
                else if (!s_icb_rsp_valid && cnt_inc >= TOUT_LIM)
                    state_nxt = TOUT;
            end
            TOUT: if (own_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            lock     <= 1'b0;
            lock_gnt <= 1'b0;
            owner    <= 1'b0;
            cnt      <= 16'd0;
            tout_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            tout_q <= in_busy && (state_nxt == TOUT);
            if (cmd_hs) begin
                owner    <= gnt;
                last_gnt <= gnt;
                lock     <= 1'b0;
                cnt      <= 16'd0;
            end else if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
                lock     <= 1'b1;
                lock_gnt <= gnt;
            end
            if (in_busy && !s_icb_rsp_valid)
                cnt <= cnt_inc;
        end
    end

endmodule
